frame_sequencer: RTL and testbench

FRAME_SEQUENCER -- requirements
Module: frame_sequencer

---
 rtl/render_pkg.sv | 18 +
 rtl/frame_sequencer.sv | 126 ++++++++++++
 tb/tb_frame_sequencer.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/render_pkg.sv
// Shared types and default frame-buffer geometry for the frame sequencer.
package render_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_CLEAR      = 3'd1,
        ST_START      = 3'd2,
        ST_RENDER     = 3'd3,
        ST_WAIT_VSYNC = 3'd4,
        ST_SWAP       = 3'd5
    } state_t;

    localparam int unsigned DEF_FB_PIXELS   = 307200;
    localparam logic [19:0] DEF_BUF0_BASE   = 20'h00000;
    localparam logic [19:0] DEF_BUF1_BASE   = 20'h4B000;
    localparam logic [15:0] DEF_CLEAR_COLOR = 16'h0000;

endpackage

// File: rtl/frame_sequencer.sv
// Double-buffered frame sequencer: clears the back buffer, lets the renderer draw
// into it, then swaps front/back on the first vertical blank after the frame completes.
module frame_sequencer
    import render_pkg::*;
#(
    parameter int unsigned FB_PIXELS   = DEF_FB_PIXELS,
    parameter logic [19:0] BUF0_BASE   = DEF_BUF0_BASE,
    parameter logic [19:0] BUF1_BASE   = DEF_BUF1_BASE,
    parameter logic [15:0] CLEAR_COLOR = DEF_CLEAR_COLOR
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic        vsync,
    input  logic        completed_frame,
    input  logic        rf_SRAM_write_enable,
    input  logic [19:0] rf_SRAM_address,
    input  logic [15:0] rf_SRAM_data,
    output logic        begin_frame,
    output logic [19:0] SRAM_address_offset,
    output logic [19:0] display_offset,
    output logic        SRAM_write_enable,
    output logic [19:0] SRAM_address,
    output logic [15:0] SRAM_data,
    output logic [15:0] frame_count,
    output logic        busy,
    output state_t      state_dbg
);

    localparam logic [19:0] LAST_PIXEL = 20'(FB_PIXELS - 1);

    state_t      state_q, state_d;
    logic [19:0] counter_q, counter_d;
    logic [15:0] frame_count_q, frame_count_d;
    logic [19:0] back_base_q, back_base_d;
    logic [19:0] front_base_q, front_base_d;
    logic        cf_prev_q, vs_prev_q;

    logic cf_rise;
    logic vs_rise;

    // The registered copies track the inputs in every state, so a level that is
    // already high when a state is entered never looks like a fresh edge.
    assign cf_rise = completed_frame & ~cf_prev_q;
    assign vs_rise = vsync & ~vs_prev_q;

    always_comb begin
        state_d       = state_q;
        counter_d     = counter_q;
        frame_count_d = frame_count_q;
        back_base_d   = back_base_q;
        front_base_d  = front_base_q;
        unique case (state_q)
            ST_IDLE: begin
                counter_d = '0;
                if (enable) state_d = ST_CLEAR;
            end
            ST_CLEAR: begin
                if (counter_q == LAST_PIXEL) begin
                    counter_d = '0;
                    state_d   = ST_START;
                end else begin
                    counter_d = counter_q + 20'd1;
                end
            end
            ST_START: state_d = ST_RENDER;
            ST_RENDER: begin
                if (cf_rise) state_d = ST_WAIT_VSYNC;
            end
            ST_WAIT_VSYNC: begin
                if (vs_rise) state_d = ST_SWAP;
            end
            ST_SWAP: begin
                back_base_d   = front_base_q;
                front_base_d  = back_base_q;
                frame_count_d = frame_count_q + 16'd1;
                state_d       = enable ? ST_CLEAR : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            counter_q     <= '0;
            frame_count_q <= '0;
            back_base_q   <= BUF1_BASE;
            front_base_q  <= BUF0_BASE;
            cf_prev_q     <= 1'b0;
            vs_prev_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            counter_q     <= counter_d;
            frame_count_q <= frame_count_d;
            back_base_q   <= back_base_d;
            front_base_q  <= front_base_d;
            cf_prev_q     <= completed_frame;
            vs_prev_q     <= vsync;
        end
    end

    // SRAM port: clear engine in CLEAR, renderer pass-through in RENDER, idle otherwise.
    always_comb begin
        SRAM_write_enable = 1'b0;
        SRAM_address      = '0;
        SRAM_data         = '0;
        if (state_q == ST_CLEAR) begin
            SRAM_write_enable = 1'b1;
            SRAM_address      = back_base_q + counter_q;
            SRAM_data         = CLEAR_COLOR;
        end else if (state_q == ST_RENDER) begin
            SRAM_write_enable = rf_SRAM_write_enable;
            SRAM_address      = rf_SRAM_address;
            SRAM_data         = rf_SRAM_data;
        end
    end

    assign begin_frame         = (state_q == ST_START);
    assign busy                = (state_q != ST_IDLE);
    assign SRAM_address_offset = back_base_q;
    assign display_offset      = front_base_q;
    assign frame_count         = frame_count_q;
    assign state_dbg           = state_q;

endmodule

// File: tb/tb_frame_sequencer.sv
// Frame-level bench: a model of the two buffer bases and the swap counter predicts
// every clear burst, pass-through write and swap for randomized frame timing.
module tb_frame_sequencer;
    import render_pkg::*;

    localparam int          FB          = 4;
    localparam logic [19:0] B0          = 20'h00000;
    localparam logic [19:0] B1          = 20'h4B000;
    localparam logic [15:0] CLEAR_COLOR = 16'h0000;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic        vsync;
    logic        completed_frame;
    logic        rf_we;
    logic [19:0] rf_addr;
    logic [15:0] rf_data;
    logic        begin_frame;
    logic [19:0] sram_address_offset;
    logic [19:0] display_offset;
    logic        sram_we;
    logic [19:0] sram_addr;
    logic [15:0] sram_data;
    logic [15:0] frame_count;
    logic        busy;
    state_t      state_dbg;

    int n_checks = 0;
    int n_pass   = 0;

    // model: back/front buffer bases and number of completed swaps
    logic [19:0] exp_back;
    logic [19:0] exp_front;
    logic [15:0] exp_fc;

    frame_sequencer #(
        .FB_PIXELS  (FB),
        .BUF0_BASE  (B0),
        .BUF1_BASE  (B1),
        .CLEAR_COLOR(CLEAR_COLOR)
    ) dut (
        .clock               (clock),
        .reset               (reset),
        .enable              (enable),
        .vsync               (vsync),
        .completed_frame     (completed_frame),
        .rf_SRAM_write_enable(rf_we),
        .rf_SRAM_address     (rf_addr),
        .rf_SRAM_data        (rf_data),
        .begin_frame         (begin_frame),
        .SRAM_address_offset (sram_address_offset),
        .display_offset      (display_offset),
        .SRAM_write_enable   (sram_we),
        .SRAM_address        (sram_addr),
        .SRAM_data           (sram_data),
        .frame_count         (frame_count),
        .busy                (busy),
        .state_dbg           (state_dbg)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    endtask

    // inputs change and outputs are sampled at the falling edge
    task automatic step();
        @(negedge clock);
    endtask

    task automatic check_bases(input string tag);
        check({tag, " back"}, 32'(sram_address_offset), 32'(exp_back));
        check({tag, " front"}, 32'(display_offset), 32'(exp_front));
        check({tag, " fcount"}, 32'(frame_count), 32'(exp_fc));
    endtask

    // Entered at the falling edge of the first CLEAR cycle; leaves one cycle after SWAP.
    task automatic run_frame(input bit coincide, input bit drop_enable, input bit fixed_write,
                             input int render_cycles, input int vs_delay);
        for (int i = 0; i < FB; i++) begin
            check("clr we", 32'(sram_we), 32'd1);
            check("clr addr", 32'(sram_addr), 32'(exp_back + 20'(i)));
            check("clr data", 32'(sram_data), 32'(CLEAR_COLOR));
            check("clr bf", 32'(begin_frame), 32'd0);
            step();
        end
        rf_we = 1'b1; rf_addr = 20'($urandom); rf_data = 16'($urandom);
        #1;
        check("start bf", 32'(begin_frame), 32'd1);
        check("start we", 32'(sram_we), 32'd0);
        check("start busy", 32'(busy), 32'd1);
        step();
        for (int r = 0; r < render_cycles; r++) begin
            if (fixed_write && r == 0) begin
                rf_we = 1'b1; rf_addr = 20'h4B010; rf_data = 16'hF800;
            end else begin
                rf_we = 1'($urandom_range(0, 1)); rf_addr = 20'($urandom); rf_data = 16'($urandom);
            end
            if (drop_enable && r == 0) enable = 1'b0;
            #1;
            check("rnd we", 32'(sram_we), 32'(rf_we));
            check("rnd addr", 32'(sram_addr), 32'(rf_addr));
            check("rnd data", 32'(sram_data), 32'(rf_data));
            check("rnd bf", 32'(begin_frame), 32'd0);
            step();
        end
        rf_we = 1'b0;
        completed_frame = 1'b1;
        if (coincide) vsync = 1'b1;
        step();
        completed_frame = 1'b0;
        vsync = 1'b0;
        rf_we = 1'b1; rf_addr = 20'h4B010; rf_data = 16'hF800;
        #1;
        check("wv we", 32'(sram_we), 32'd0);
        check("wv addr", 32'(sram_addr), 32'd0);
        check("wv data", 32'(sram_data), 32'd0);
        rf_we = 1'b0;
        for (int d = 0; d < vs_delay; d++) begin
            step();
            check("wv busy", 32'(busy), 32'd1);
            check_bases("wv");
        end
        vsync = 1'b1;
        step();
        vsync = 1'b0;
        check("swap busy", 32'(busy), 32'd1);
        check("swap we", 32'(sram_we), 32'd0);
        check("swap bf", 32'(begin_frame), 32'd0);
        {exp_back, exp_front} = {exp_front, exp_back};
        exp_fc = exp_fc + 16'd1;
        step();
        check_bases("post swap");
        check("post swap busy", 32'(busy), 32'(enable));
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; vsync = 1'b0; completed_frame = 1'b0;
        rf_we = 1'b0; rf_addr = '0; rf_data = '0;
        exp_back = B1; exp_front = B0; exp_fc = '0;
        repeat (3) step();
        check("rst busy", 32'(busy), 32'd0);
        check("rst we", 32'(sram_we), 32'd0);
        check("rst bf", 32'(begin_frame), 32'd0);
        check_bases("rst");
        reset = 1'b0;
        step();
        check("idle busy", 32'(busy), 32'd0);

        enable = 1'b1;
        step();
        run_frame(1'b0, 1'b0, 1'b1, 3, 10);
        run_frame(1'b1, 1'b0, 1'b0, 2, 4);
        for (int f = 0; f < 3; f++)
            run_frame(1'($urandom_range(0, 1)), 1'b0, 1'b0,
                      $urandom_range(1, 6), $urandom_range(1, 5));
        run_frame(1'b0, 1'b1, 1'b0, 3, 2);
        for (int k = 0; k < 5; k++) begin
            check("idle bf", 32'(begin_frame), 32'd0);
            check("idle busy", 32'(busy), 32'd0);
            check("idle we", 32'(sram_we), 32'd0);
            step();
        end
        check_bases("idle");

        enable = 1'b1;
        step();
        step();
        step();
        check("midclr addr", 32'(sram_addr), 32'(exp_back + 20'd2));
        reset = 1'b1;
        step();
        exp_back = B1; exp_front = B0; exp_fc = '0;
        check("midrst busy", 32'(busy), 32'd0);
        check("midrst we", 32'(sram_we), 32'd0);
        check_bases("midrst");
        reset = 1'b0;
        step();
        run_frame(1'b0, 1'b0, 1'b0, 2, 3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
